dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache controller placed directly downstream of the ALU.
- Takes the ALU result as the byte address of a load/store and serves hits in the same cycle.
- On a miss or store, stalls the core while it talks to main memory over a ready-based handshake.
- Replaces the bare data memory on the core's memory-stage path.

---
 rtl/dcache_ctrl_if.sv | 22 ++
 rtl/dcache_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// Main-memory side of the data cache: word-wide read/write requests
// completed by a single mem_ready handshake per beat.
interface dcache_ctrl_if;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  // Cache controller side: issues requests, consumes responses.
  modport master (
    output mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  // Memory side: accepts requests, returns read data and ready.
  modport slave (
    input  mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Load hits are served combinationally; misses refill a whole block one
// word per ready beat; stores always go to memory and update the line
// only if it is already present.
module dcache_ctrl #(
  parameter int INDEX_BITS  = 5,
  parameter int OFFSET_BITS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  input  logic         cpu_mem_read,
  input  logic         cpu_mem_write,
  output logic [31:0]  cpu_rdata,
  output logic         stall,
  dcache_ctrl_if.master mem
);
  localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [OFFSET_BITS-1:0] beat_q, beat_d;
  logic [31:2]            req_addr_q, req_addr_d;
  logic                   mem_rd_req_q, mem_rd_req_d;
  logic                   mem_wr_req_q, mem_wr_req_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;
  logic [LINES-1:0]       valid_q, valid_d;

  // Tag and data arrays carry no reset; only the valid bits are cleared.
  logic [TAG_BITS-1:0]    tag_q  [LINES];
  logic [31:0]            data_q [LINES][WORDS];

  logic [TAG_BITS-1:0]    cpu_tag_s, req_tag_s;
  logic [INDEX_BITS-1:0]  cpu_idx_s, req_idx_s;
  logic [OFFSET_BITS-1:0] cpu_off_s, req_off_s;
  logic                   hit_s, req_hit_s, load_hit_s;
  logic                   tag_we_s, word_we_s;
  logic [OFFSET_BITS-1:0] word_off_s;
  logic [31:0]            word_data_s;
  logic                   unused_addr_s;

  assign cpu_tag_s = cpu_addr[31 -: TAG_BITS];
  assign cpu_idx_s = cpu_addr[OFFSET_BITS+2 +: INDEX_BITS];
  assign cpu_off_s = cpu_addr[2 +: OFFSET_BITS];
  assign req_tag_s = req_addr_q[31 -: TAG_BITS];
  assign req_idx_s = req_addr_q[OFFSET_BITS+2 +: INDEX_BITS];
  assign req_off_s = req_addr_q[2 +: OFFSET_BITS];
  // Byte-within-word bits play no part in a word-only cache.
  assign unused_addr_s = ^cpu_addr[1:0];

  assign hit_s      = valid_q[cpu_idx_s] && (tag_q[cpu_idx_s] == cpu_tag_s);
  assign req_hit_s  = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
  assign load_hit_s = cpu_mem_read && !cpu_mem_write && hit_s;

  assign mem.mem_rd_req = mem_rd_req_q;
  assign mem.mem_wr_req = mem_wr_req_q;
  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_wdata  = mem_wdata_q;

  // Core-facing outputs: zero-latency hit data and the stall decision.
  always_comb begin
    stall     = 1'b0;
    cpu_rdata = 32'd0;
    case (state_q)
      S_IDLE: begin
        stall     = (cpu_mem_read || cpu_mem_write) && !load_hit_s;
        cpu_rdata = load_hit_s ? data_q[cpu_idx_s][cpu_off_s] : 32'd0;
      end
      S_REFILL: stall = 1'b1;
      S_WRITE:  stall = 1'b1;
      S_DONE:   stall = 1'b0;
      default:  stall = 1'b0;
    endcase
  end

  // Next-state, request-register and array write-enable computation.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    req_addr_d   = req_addr_q;
    mem_rd_req_d = mem_rd_req_q;
    mem_wr_req_d = mem_wr_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    valid_d      = valid_q;
    tag_we_s     = 1'b0;
    word_we_s    = 1'b0;
    word_off_s   = beat_q;
    word_data_s  = mem.mem_rdata;
    case (state_q)
      S_IDLE: begin
        if (cpu_mem_write) begin
          // Read+write together is a store.
          state_d      = S_WRITE;
          req_addr_d   = cpu_addr[31:2];
          mem_wr_req_d = 1'b1;
          mem_addr_d   = {cpu_addr[31:2], 2'b00};
          mem_wdata_d  = cpu_wdata;
        end else if (cpu_mem_read && !hit_s) begin
          // Invalidate up front so an aborted refill leaves no stale line.
          state_d             = S_REFILL;
          beat_d              = {OFFSET_BITS{1'b0}};
          req_addr_d          = cpu_addr[31:2];
          valid_d[cpu_idx_s]  = 1'b0;
          mem_rd_req_d        = 1'b1;
          mem_addr_d          = {cpu_addr[31:OFFSET_BITS+2], {OFFSET_BITS{1'b0}}, 2'b00};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REFILL: begin
        if (mem.mem_ready) begin
          word_we_s = 1'b1;
          beat_d    = beat_q + 1'b1;
          if (beat_q == {OFFSET_BITS{1'b1}}) begin
            tag_we_s           = 1'b1;
            valid_d[req_idx_s] = 1'b1;
            state_d            = S_IDLE;
            mem_rd_req_d       = 1'b0;
            mem_addr_d         = 32'd0;
          end else begin
            mem_addr_d = mem_addr_q + 32'd4;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      S_WRITE: begin
        if (mem.mem_ready) begin
          if (req_hit_s) begin
            word_we_s   = 1'b1;
            word_off_s  = req_off_s;
            word_data_s = mem_wdata_q;
          end else begin
            word_we_s = 1'b0;
          end
          state_d      = S_DONE;
          mem_wr_req_d = 1'b0;
          mem_addr_d   = 32'd0;
          mem_wdata_d  = 32'd0;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state and registered memory-request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_q       <= {OFFSET_BITS{1'b0}};
      req_addr_q   <= 30'd0;
      mem_rd_req_q <= 1'b0;
      mem_wr_req_q <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      valid_q      <= {LINES{1'b0}};
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      req_addr_q   <= req_addr_d;
      mem_rd_req_q <= mem_rd_req_d;
      mem_wr_req_q <= mem_wr_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      valid_q      <= valid_d;
    end
  end

  // Tag and data array writes (refill beats and store hits).
  always_ff @(posedge clk) begin
    if (tag_we_s) begin
      tag_q[req_idx_s] <= req_tag_s;
    end
    if (word_we_s) begin
      data_q[req_idx_s][word_off_s] <= word_data_s;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a driver issues loads/stores and pushes
// the expected outcome from an abstract cache model; a monitor pops and
// compares whenever the core-side request retires (stall low).
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_mem_read, cpu_mem_write, stall;

  dcache_ctrl_if mif ();

  dcache_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_mem_read (cpu_mem_read),
    .cpu_mem_write(cpu_mem_write),
    .cpu_rdata    (cpu_rdata),
    .stall        (stall),
    .mem          (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_store;
    logic [31:0] addr;
    logic [31:0] data;
    bit          hit;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Abstract reference: which tag each line holds, and memory contents.
  bit          ref_valid [32];
  logic [22:0] ref_tag   [32];
  logic [31:0] ref_mem   [logic [31:0]];
  // Backing store seen by the memory responder.
  logic [31:0] phys_mem  [logic [31:0]];

  int wait_lo = 0;
  int wait_hi = 0;
  int wait_cnt = 0;

  logic [31:0] rd_log[$];
  logic [63:0] wr_log[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic exp_t model_op(bit st, logic [31:0] a, logic [31:0] d);
    exp_t        e;
    logic [31:0] wa;
    int          idx;
    logic [22:0] tag;
    wa  = {a[31:2], 2'b00};
    idx = int'(a[8:4]);
    tag = a[31:9];
    e.is_store = st;
    e.addr     = wa;
    e.hit      = ref_valid[idx] && (ref_tag[idx] == tag);
    if (st) begin
      ref_mem[wa] = d;
      e.data      = d;
    end else begin
      e.data = ref_mem.exists(wa) ? ref_mem[wa] : wa;
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tag;
    end
    return e;
  endfunction

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Memory responder: programmable wait states, word = address when unwritten.
  initial begin
    bit acc;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      acc = mif.mem_ready && (mif.mem_rd_req || mif.mem_wr_req);
      if (mif.mem_ready && mif.mem_wr_req && !rst) phys_mem[mif.mem_addr] = mif.mem_wdata;
      if (acc) wait_cnt = $urandom_range(wait_hi, wait_lo);
      @(posedge clk);
      #1;
      if (mif.mem_rd_req || mif.mem_wr_req) begin
        if (wait_cnt == 0) begin
          mif.mem_ready = 1'b1;
          mif.mem_rdata = phys_mem.exists(mif.mem_addr) ? phys_mem[mif.mem_addr] : mif.mem_addr;
        end else begin
          mif.mem_ready = 1'b0;
          mif.mem_rdata = $urandom;
          wait_cnt--;
        end
      end else begin
        mif.mem_ready = 1'($urandom_range(1, 0));
        mif.mem_rdata = $urandom;
        wait_cnt      = $urandom_range(wait_hi, wait_lo);
      end
    end
  end

  // Monitor: protocol checks every cycle, scoreboard pop on each retire.
  initial begin
    exp_t        e;
    logic        prev_wr = 1'b0;
    logic [31:0] prev_addr = 32'd0, prev_wdata = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_log.delete();
        wr_log.delete();
        prev_wr = 1'b0;
      end else begin
        check("req_onehot", {31'd0, mif.mem_rd_req && mif.mem_wr_req}, 32'd0);
        if (prev_wr && mif.mem_wr_req) begin
          check("wr_addr_stable", mif.mem_addr, prev_addr);
          check("wr_data_stable", mif.mem_wdata, prev_wdata);
        end
        prev_wr    = mif.mem_wr_req;
        prev_addr  = mif.mem_addr;
        prev_wdata = mif.mem_wdata;
        if (mif.mem_ready && mif.mem_rd_req) rd_log.push_back(mif.mem_addr);
        if (mif.mem_ready && mif.mem_wr_req) wr_log.push_back({mif.mem_addr, mif.mem_wdata});
        if (!(cpu_mem_read && !cpu_mem_write && !stall)) check("rdata_zero", cpu_rdata, 32'd0);
        if (!cpu_mem_read && !cpu_mem_write) begin
          check("idle_stall", {31'd0, stall}, 32'd0);
        end else if (!stall) begin
          if (exp_q.size() == 0) begin
            check("unexpected_retire", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            if (e.is_store) begin
              check("st_wr_beats", 32'(wr_log.size()), 32'd1);
              check("st_rd_beats", 32'(rd_log.size()), 32'd0);
              if (wr_log.size() == 1) begin
                check("st_mem_addr", wr_log[0][63:32], e.addr);
                check("st_mem_data", wr_log[0][31:0], e.data);
              end
            end else begin
              check("ld_data", cpu_rdata, e.data);
              check("ld_rd_beats", 32'(rd_log.size()), e.hit ? 32'd0 : 32'd4);
              check("ld_wr_beats", 32'(wr_log.size()), 32'd0);
              if (!e.hit && rd_log.size() == 4) begin
                for (int i = 0; i < 4; i++)
                  check("refill_addr", rd_log[i], {e.addr[31:4], 4'h0} + 32'(4 * i));
              end
            end
          end
          rd_log.delete();
          wr_log.delete();
        end
      end
    end
  end

  // Issue one access at posedge+1 and wait (bounded) for it to retire.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, output int ncyc);
    bit done = 1'b0;
    cpu_addr      = a;
    cpu_wdata     = d;
    cpu_mem_read  = rd;
    cpu_mem_write = wr;
    exp_q.push_back(model_op(wr, a, d));
    ncyc = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
      else ncyc++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL op_timeout: addr 0x%08h still stalled, expected retire", a);
      finish_run();
    end
    @(posedge clk);
    #1;
    cpu_mem_read  = 1'b0;
    cpu_mem_write = 1'b0;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not end, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic [31:0] a;
    int          r;
    rst = 1'b1;
    cpu_addr = 32'd0; cpu_wdata = 32'd0;
    cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
    clear_ref();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rd_req", {31'd0, mif.mem_rd_req}, 32'd0);
    check("rst_wr_req", {31'd0, mif.mem_wr_req}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    @(posedge clk);
    #1;

    // Read miss with zero wait states, then hits in the same block.
    do_op(1'b1, 1'b0, 32'h40, 32'd0, n);
    check("t1_stall_cycles", 32'(n), 32'd5);
    do_op(1'b1, 1'b0, 32'h44, 32'd0, n);
    check("t2_hit_44", 32'(n), 32'd0);
    do_op(1'b1, 1'b0, 32'h48, 32'd0, n);
    check("t2_hit_48", 32'(n), 32'd0);
    do_op(1'b1, 1'b0, 32'h4C, 32'd0, n);
    check("t2_hit_4c", 32'(n), 32'd0);

    // Store hit with three wait states, then reload it from the cache.
    wait_lo = 3; wait_hi = 3;
    do_op(1'b0, 1'b1, 32'h48, 32'hDEADBEEF, n);
    check("t3_store_stall", 32'(n), 32'd5);
    wait_lo = 0; wait_hi = 2;
    do_op(1'b1, 1'b0, 32'h48, 32'd0, n);
    check("t3_load_hit", 32'(n), 32'd0);

    // Store miss does not allocate; conflicting tags evict each other.
    do_op(1'b0, 1'b1, 32'h1000, 32'h12345678, n);
    do_op(1'b1, 1'b0, 32'h1000, 32'd0, n);
    do_op(1'b1, 1'b0, 32'h40, 32'd0, n);
    do_op(1'b1, 1'b0, 32'h240, 32'd0, n);
    do_op(1'b1, 1'b0, 32'h40, 32'd0, n);

    // Reset in the middle of a refill (beat 2) of 0x80.
    wait_lo = 0; wait_hi = 0;
    do_op(1'b1, 1'b0, 32'h280, 32'd0, n);
    cpu_addr = 32'h80;
    cpu_mem_read = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("t6_beat2_addr", mif.mem_addr, 32'h88);
    rst = 1'b1;
    cpu_mem_read = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_ref();
    @(negedge clk);
    check("t6_post_rd_req", {31'd0, mif.mem_rd_req}, 32'd0);
    check("t6_post_wr_req", {31'd0, mif.mem_wr_req}, 32'd0);
    check("t6_post_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    do_op(1'b1, 1'b0, 32'h80, 32'd0, n);
    do_op(1'b1, 1'b0, 32'h280, 32'd0, n);

    // Randomized mix over a small address pool to force hits and conflicts.
    wait_lo = 0; wait_hi = 2;
    for (int i = 0; i < 250; i++) begin
      a = (32'($urandom_range(3, 0)) << 9) | (32'($urandom_range(31, 0)) << 4) |
          (32'($urandom_range(3, 0)) << 2) | 32'($urandom_range(3, 0));
      r = $urandom_range(9, 0);
      if (r <= 5)      do_op(1'b1, 1'b0, a, 32'd0, n);
      else if (r <= 8) do_op(1'b0, 1'b1, a, $urandom, n);
      else             do_op(1'b1, 1'b1, a, $urandom, n);
      if ($urandom_range(3, 0) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    finish_run();
  end
endmodule
